pll_phase_ctrl: RTL and testbench

// Sequencer for the ECP5 EHXPLLL: runs the PLL reset/lock bring-up, generates the downstream

---
 rtl/pll_phase_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL sequencer: PLL reset/lock bring-up, downstream system reset generation
// and dynamic phase-shift stepping on the PHASESEL/PHASEDIR/PHASESTEP pins.
module pll_phase_ctrl #(
  parameter int RST_CYC      = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int SETTLE_CYC   = 8,
  parameter int STEP_W       = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              sys_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              done,
  output logic              busy,
  output logic [7:0]        relock_cnt
);

  localparam int MAX_A   = (RST_CYC > LOCK_STABLE) ? RST_CYC : LOCK_STABLE;
  localparam int MAX_B   = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int MAX_C   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_D   = (MAX_C > SETTLE_CYC) ? MAX_C : SETTLE_CYC;
  localparam int MAX_CNT = (MAX_B > MAX_D) ? MAX_B : MAX_D;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   remain_q, remain_d;
  logic [1:0]          sync_q, sync_d;
  logic                pll_rst_q, pll_rst_d;
  logic [1:0]          phasesel_q, phasesel_d;
  logic                phasedir_q, phasedir_d;
  logic                phasestep_q, phasestep_d;
  logic                sys_reset_n_q, sys_reset_n_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [7:0]          relock_q, relock_d;
  logic                locked_s;
  logic                in_service;

  assign locked_s   = sync_q[1];
  assign sync_d     = {sync_q[0], pll_locked};
  assign in_service = (state_q == ST_IDLE) || (state_q == ST_SETUP) ||
                      (state_q == ST_PULSE) || (state_q == ST_SETTLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    remain_d      = remain_q;
    pll_rst_d     = pll_rst_q;
    phasesel_d    = phasesel_q;
    phasedir_d    = phasedir_q;
    phasestep_d   = phasestep_q;
    sys_reset_n_d = sys_reset_n_q;
    done_d        = 1'b0;
    busy_d        = busy_q;
    relock_d      = relock_q;

    unique case (state_q)
      ST_RST_PLL: begin
        pll_rst_d = 1'b1;
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // The locked cycle that ends the wait already counts toward stability.
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d   = ST_RST_PLL;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          sys_reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          if (req_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_SETUP;
            cnt_d      = '0;
            busy_d     = 1'b1;
            phasesel_d = req_sel;
            phasedir_d = req_dir;
            remain_d   = req_steps;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d     = ST_PULSE;
          cnt_d       = '0;
          phasestep_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d     = ST_SETTLE;
          cnt_d       = '0;
          phasestep_d = 1'b1;
          remain_d    = remain_q - STEP_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d = '0;
          if (remain_q == '0) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            phasedir_d = 1'b1;
          end else begin
            state_d     = ST_PULSE;
            phasestep_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RST_PLL;
        cnt_d   = '0;
      end
    endcase

    // Losing lock after bring-up overrides everything: abort and restart the PLL.
    if (in_service && !locked_s) begin
      state_d       = ST_RST_PLL;
      cnt_d         = '0;
      pll_rst_d     = 1'b1;
      sys_reset_n_d = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      phasestep_d   = 1'b1;
      phasedir_d    = 1'b1;
      relock_d      = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RST_PLL;
      cnt_q         <= '0;
      remain_q      <= '0;
      sync_q        <= '0;
      pll_rst_q     <= 1'b1;
      phasesel_q    <= 2'd0;
      phasedir_q    <= 1'b1;
      phasestep_q   <= 1'b1;
      sys_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      relock_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      remain_q      <= remain_d;
      sync_q        <= sync_d;
      pll_rst_q     <= pll_rst_d;
      phasesel_q    <= phasesel_d;
      phasedir_q    <= phasedir_d;
      phasestep_q   <= phasestep_d;
      sys_reset_n_q <= sys_reset_n_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      relock_q      <= relock_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b1;
  assign sys_reset_n  = sys_reset_n_q;
  assign req_ready    = (state_q == ST_IDLE);
  assign done         = done_q;
  assign busy         = busy_q;
  assign relock_cnt   = relock_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: behavioural PLL lock model plus directed and
// randomized phase requests compared against timing rules computed from first principles.
module tb_pll_phase_ctrl;

  localparam int RST_CYC      = 16;
  localparam int LOCK_STABLE  = 1024;
  localparam int LOCK_TIMEOUT = 65535;
  localparam int SETUP_CYC    = 2;
  localparam int PULSE_CYC    = 4;
  localparam int SETTLE_CYC   = 8;
  localparam int LOCK_DELAY   = 100;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       sys_reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       done;
  logic       busy;
  logic [7:0] relock_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  bit never_lock   = 1'b0;
  bit drop         = 1'b0;
  int lock_cnt     = 0;

  pll_phase_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .sys_reset_n  (sys_reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .done         (done),
    .busy         (busy),
    .relock_cnt   (relock_cnt)
  );

  always #20 clock = ~clock;

  // PLL model: lock asserts LOCK_DELAY cycles after RST falls, unless disabled or dropped.
  always @(posedge clock) begin
    #1;
    if (pll_rst !== 1'b0) begin
      lock_cnt   = 0;
      pll_locked = 1'b0;
    end else begin
      if (lock_cnt < 1000000) lock_cnt++;
      pll_locked = (lock_cnt >= LOCK_DELAY) && !never_lock && !drop;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests_run++;
    assert (obs >= lo && obs <= hi) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_pll_rst"},      32'(pll_rst), 1);
    check_output({tag, "_phasesel"},     32'(phasesel), 0);
    check_output({tag, "_phasedir"},     32'(phasedir), 1);
    check_output({tag, "_phasestep"},    32'(phasestep), 1);
    check_output({tag, "_phaseloadreg"}, 32'(phaseloadreg), 1);
    check_output({tag, "_sys_reset_n"},  32'(sys_reset_n), 0);
    check_output({tag, "_req_ready"},    32'(req_ready), 0);
    check_output({tag, "_done"},         32'(done), 0);
    check_output({tag, "_busy"},         32'(busy), 0);
    check_output({tag, "_relock_cnt"},   32'(relock_cnt), 0);
  endtask

  // Counts negedge samples with pll_rst high, starting with the current sample.
  task automatic measure_rst_high(output int hi);
    hi = 0;
    while (pll_rst === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clock);
    end
  endtask

  task automatic wait_bringup(output int rel_delay);
    int n;
    n = 0;
    while (pll_locked !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    rel_delay = 0;
    while (sys_reset_n !== 1'b1 && rel_delay < 2000) begin
      @(negedge clock);
      rel_delay++;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                                input bit inject, input string tag);
    int exp_lat, lat, nfall, run, bad_low, bad_gap, bad_sel, bad_busy;
    logic prev, ps;
    bit seen_low;
    exp_lat  = (steps == 0) ? 1 : SETUP_CYC + int'(steps) * (PULSE_CYC + SETTLE_CYC) + 1;
    lat      = 0;
    nfall    = 0;
    run      = 0;
    bad_low  = 0;
    bad_gap  = 0;
    bad_sel  = 0;
    bad_busy = 0;
    prev     = 1'b1;
    seen_low = 1'b0;
    check_output({tag, "_ready_idle"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = steps;
    for (int i = 1; i <= exp_lat + 20; i++) begin
      @(negedge clock);
      if (i == 1) req_valid = 1'b0;
      if (inject && i == 3) begin
        req_valid = 1'b1;
        req_sel   = ~sel;
        req_dir   = ~dir;
        req_steps = 8'd5;
      end
      if (inject && i == 9) req_valid = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      ps = phasestep;
      if (steps != 0 && phasesel !== sel) bad_sel++;
      if (ps === 1'b0 && phasedir !== dir) bad_sel++;
      if (steps != 0 && (busy !== 1'b1 || req_ready !== 1'b0)) bad_busy++;
      if (ps !== prev) begin
        if (prev == 1'b0 && run != PULSE_CYC) bad_low++;
        if (prev == 1'b1 && seen_low && run != SETTLE_CYC) bad_gap++;
        if (prev == 1'b0) seen_low = 1'b1;
        if (ps == 1'b0) nfall++;
        run  = 1;
        prev = ps;
      end else begin
        run++;
      end
    end
    if (prev == 1'b0) bad_low++;
    if (seen_low && prev == 1'b1 && run != SETTLE_CYC) bad_gap++;
    check_output({tag, "_pulses"},    32'(nfall), 32'(steps));
    check_output({tag, "_latency"},   32'(lat), 32'(exp_lat));
    check_output({tag, "_low_errs"},  32'(bad_low), 0);
    check_output({tag, "_gap_errs"},  32'(bad_gap), 0);
    check_output({tag, "_seldir_errs"}, 32'(bad_sel), 0);
    check_output({tag, "_busy_errs"}, 32'(bad_busy), 0);
    @(negedge clock);
    check_output({tag, "_done_width"}, 32'(done), 0);
    check_output({tag, "_busy_after"}, 32'(busy), 0);
    check_output({tag, "_dir_after"},  32'(phasedir), 1);
    check_output({tag, "_step_after"}, 32'(phasestep), 1);
  endtask

  initial begin
    int hi, lo, d, n, done_seen, quiet_errs, sys_bad;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    req_valid  = 1'b0;
    req_sel    = 2'd0;
    req_dir    = 1'b0;
    req_steps  = 8'd0;

    repeat (3) @(negedge clock);
    check_reset_state("por");

    // Bring-up with the PLL locking LOCK_DELAY cycles after RST falls
    reset_n = 1'b1;
    measure_rst_high(hi);
    check_output("t1_rst_high", 32'(hi), RST_CYC);
    wait_bringup(d);
    check_range("t1_sys_release", d, LOCK_STABLE + 2, LOCK_STABLE + 3);
    check_output("t1_ready", 32'(req_ready), 1);
    check_output("t1_relock", 32'(relock_cnt), 0);

    apply_stimulus(2'd2, 1'b0, 8'd3, 1'b0, "t3");

    apply_stimulus(2'd1, 1'b1, 8'd0, 1'b0, "t4_zero");
    apply_stimulus(2'd3, 1'b1, 8'd2, 1'b1, "t4_inject");
    quiet_errs = 0;
    repeat (20) begin
      @(negedge clock);
      if (phasestep !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet_errs++;
    end
    check_output("t4_quiet", 32'(quiet_errs), 0);

    for (int k = 0; k < 6; k++) begin
      apply_stimulus(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                     8'($urandom_range(6, 0)), 1'b0, $sformatf("rnd%0d", k));
    end

    // Lock lost in the middle of a step pulse
    req_valid = 1'b1;
    req_sel   = 2'd1;
    req_dir   = 1'b1;
    req_steps = 8'd3;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (phasestep !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_output("t5_pulse_seen", 32'(phasestep), 0);
    drop       = 1'b1;
    pll_locked = 1'b0;
    done_seen  = 0;
    n = 0;
    while (pll_rst !== 1'b1 && n < 8) begin
      @(negedge clock);
      n++;
      if (done === 1'b1) done_seen++;
    end
    check_output("t5_pll_rst", 32'(pll_rst), 1);
    check_output("t5_phasestep", 32'(phasestep), 1);
    check_output("t5_sys_reset_n", 32'(sys_reset_n), 0);
    check_output("t5_busy", 32'(busy), 0);
    check_output("t5_no_done", 32'(done_seen), 0);
    check_output("t5_relock", 32'(relock_cnt), 1);
    drop = 1'b0;
    measure_rst_high(hi);
    check_output("t5_rst_high", 32'(hi), RST_CYC);
    wait_bringup(d);
    check_range("t5_sys_release", d, LOCK_STABLE + 2, LOCK_STABLE + 3);
    check_output("t5_ready", 32'(req_ready), 1);
    check_output("t5_relock_kept", 32'(relock_cnt), 1);

    // Asynchronous reset in the settle gap between two steps
    req_valid = 1'b1;
    req_sel   = 2'd3;
    req_dir   = 1'b0;
    req_steps = 8'd2;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (phasestep !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (phasestep !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check_output("t6_in_settle_busy", 32'(busy), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_state("t6");

    // PLL that never locks keeps re-pulsing RST
    never_lock = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    measure_rst_high(hi);
    check_output("t2_rst_high", 32'(hi), RST_CYC);
    lo = 0;
    sys_bad = 0;
    while (pll_rst === 1'b0 && lo < 70000) begin
      if (sys_reset_n !== 1'b0) sys_bad++;
      lo++;
      @(negedge clock);
    end
    check_output("t2_rst_low", 32'(lo), LOCK_TIMEOUT);
    measure_rst_high(hi);
    check_output("t2_rst_high_again", 32'(hi), RST_CYC);
    check_output("t2_sys_held", 32'(sys_bad), 0);
    check_output("t2_sys_reset_n", 32'(sys_reset_n), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
